maze_path_deque: RTL

- Direction-history store that serves the maze-solver controller. It accepts the controller's push / pop_back / pop_front requests.
- Push appends a 2-bit move direction at the back.
- pop_back undoes the last move during backtracking.
- pop_front replays the path from the start during path display.
- Circular buffer with head/tail pointers and an occupancy counter. Back and front entries are readable combinationally, so the controller decides its next state in the same cycle.

---
 rtl/maze_pkg.sv | 17 +
 rtl/maze_path_deque_if.sv | 34 +++
 rtl/maze_ptr_wrap.sv | 37 +++
 rtl/maze_path_deque.sv | 96 +++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and sizing for the maze solver: direction encoding and the
// default path-history depth derived from the maze dimension.
package maze_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  localparam int DIR_W      = 2;
  localparam int MAZE_DIM   = 16;
  // A simple path can visit every cell at most once.
  localparam int MAZE_DEPTH = MAZE_DIM * MAZE_DIM;

endpackage

// File: rtl/maze_path_deque_if.sv
// Request/response bundle between the maze-solver controller and its
// direction-history deque.
interface maze_path_deque_if
  import maze_pkg::*;
#(
  parameter int DEPTH = MAZE_DEPTH,
  parameter int DW    = DIR_W
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          clr;
  logic          push;
  logic [DW-1:0] din;
  logic          pop_back;
  logic          pop_front;
  logic [DW-1:0] back_out;
  logic [DW-1:0] front_out;
  logic          is_empty;
  logic          is_full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output clr, push, din, pop_back, pop_front,
    input  back_out, front_out, is_empty, is_full, count, overflow, underflow
  );

  modport slave (
    input  clr, push, din, pop_back, pop_front,
    output back_out, front_out, is_empty, is_full, count, overflow, underflow
  );

endinterface

// File: rtl/maze_ptr_wrap.sv
// Modulo-DEPTH pointer that can step up or down by one; simultaneous
// inc and dec cancel. DEPTH need not be a power of two.
module maze_ptr_wrap #(
  parameter int DEPTH = 4,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (inc && !dec)
      ptr_next = (ptr_reg == PW'(DEPTH - 1)) ? '0 : ptr_reg + PW'(1);
    else if (dec && !inc)
      ptr_next = (ptr_reg == '0) ? PW'(DEPTH - 1) : ptr_reg - PW'(1);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      ptr_reg <= '0;
    else if (clr)
      ptr_reg <= '0;
    else
      ptr_reg <= ptr_next;
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/maze_path_deque.sv
// Circular direction-history deque: push/pop at the back for exploration and
// backtracking, pop at the front for path replay; both ends read combinationally.
module maze_path_deque
  import maze_pkg::*;
#(
  parameter int DEPTH = MAZE_DEPTH,
  parameter int DW    = DIR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  maze_path_deque_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [CW-1:0] cnt_after_pb;
  logic [CW-1:0] cnt_after_pf;
  logic          overflow_reg;
  logic          underflow_reg;
  logic          pb_ok, pf_ok, push_ok;
  logic          udf_evt, ovf_evt;
  logic [PW-1:0] tail_prev;
  logic [PW-1:0] waddr;

  // Index 0 is head (oldest entry), index 1 is tail (next free slot).
  logic [1:0]    ptr_inc;
  logic [1:0]    ptr_dec;
  logic [PW-1:0] ptr_q [2];

  // Ops resolve in the order pop_back, pop_front, push against a running count.
  always_comb begin
    pb_ok        = bus.pop_back && (count_reg != '0);
    cnt_after_pb = count_reg - CW'(pb_ok);
    pf_ok        = bus.pop_front && (cnt_after_pb != '0);
    cnt_after_pf = cnt_after_pb - CW'(pf_ok);
    push_ok      = bus.push && (cnt_after_pf != CW'(DEPTH));
    count_next   = cnt_after_pf + CW'(push_ok);
    udf_evt      = (bus.pop_back && !pb_ok) || (bus.pop_front && !pf_ok);
    ovf_evt      = bus.push && !push_ok;
  end

  assign ptr_inc = {push_ok, pf_ok};
  assign ptr_dec = {pb_ok, 1'b0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      maze_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_ptr (
        .Clk (Clk),
        .Rst (Rst),
        .clr (bus.clr),
        .inc (ptr_inc[gi]),
        .dec (ptr_dec[gi]),
        .ptr (ptr_q[gi])
      );
    end
  endgenerate

  assign tail_prev = (ptr_q[1] == '0) ? PW'(DEPTH - 1) : ptr_q[1] - PW'(1);
  // A push paired with pop_back overwrites the slot the pop just released.
  assign waddr     = pb_ok ? tail_prev : ptr_q[1];

  always_ff @(posedge Clk) begin
    if (push_ok && !bus.clr)
      mem[waddr] <= bus.din;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (bus.clr) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      overflow_reg  <= overflow_reg | ovf_evt;
      underflow_reg <= underflow_reg | udf_evt;
    end
  end

  assign bus.back_out  = (count_reg == '0) ? '0 : mem[tail_prev];
  assign bus.front_out = (count_reg == '0) ? '0 : mem[ptr_q[0]];
  assign bus.is_empty  = (count_reg == '0);
  assign bus.is_full   = (count_reg == CW'(DEPTH));
  assign bus.count     = count_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;

endmodule
